// File: rtl/mem_wait_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encodings and the default
// byte address that maps to data-memory word 0.
package mem_stage_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/mem_wait_stage_data_memory_array.sv
// Word-addressed data memory: asynchronous read, synchronous write.
// No reset; contents survive pipeline reset.
module data_memory_array #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      wdata,
  output logic [N-1:0]      rdata
);

  logic [N-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_wait_stage.sv
// MEM stage with fixed-latency data memory: ready is low for WAIT_CYCLES+1
// cycles per access (freezing upstream), results land in MEM/WB after DONE.
module mem_wait_stage
  import mem_stage_defs::*;
#(
  parameter int N           = 32,
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ALU_ResIn,
  input  logic [N-1:0] Value_RmIn,
  input  logic         MEM_R_ENIn,
  input  logic         MEM_W_ENIn,
  input  logic         WB_ENIn,
  input  logic [3:0]   DestIn,
  output logic         ready,
  output logic         WB_ENOut,
  output logic         MEM_R_ENOut,
  output logic [N-1:0] ALU_ResOut,
  output logic [N-1:0] DataMemoryOut,
  output logic [3:0]   DestOut,
  output logic         addr_err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [N:0] LIMIT = (N+1)'(4) << ADDR_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               wb_en_q, wb_en_d;
  logic               mem_r_en_q, mem_r_en_d;
  logic [N-1:0]       alu_res_q, alu_res_d;
  logic [N-1:0]       data_q, data_d;
  logic [3:0]         dest_q, dest_d;
  logic               addr_err_q, addr_err_d;

  logic               req;
  logic               is_read;
  logic               in_range;
  logic               mem_we;
  logic [N-1:0]       offset;
  logic [ADDR_W-1:0]  word_addr;
  logic [N-1:0]       rd_data;

  assign req       = MEM_R_ENIn | MEM_W_ENIn;
  // A write wins when both enables are set.
  assign is_read   = MEM_R_ENIn & ~MEM_W_ENIn;
  assign offset    = ALU_ResIn - N'(BASE_ADDR);
  assign in_range  = ({1'b0, offset} < LIMIT);
  assign word_addr = offset[ADDR_W+1:2];
  assign mem_we    = (state_q == S_DONE) & MEM_W_ENIn & in_range & ~rst;

  data_memory_array #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_addr),
    .wdata (Value_RmIn),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          ready   = 1'b0;
        end
      end
      S_BUSY: begin
        ready = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stalled cycles push a bubble; data fields simply hold.
  always_comb begin
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    addr_err_d = 1'b0;
    alu_res_d  = alu_res_q;
    data_d     = data_q;
    dest_d     = dest_q;
    if (ready) begin
      wb_en_d    = WB_ENIn;
      mem_r_en_d = is_read;
      addr_err_d = req & ~in_range;
      alu_res_d  = ALU_ResIn;
      data_d     = in_range ? rd_data : '0;
      dest_d     = DestIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      data_q     <= '0;
      dest_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_res_q  <= alu_res_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign WB_ENOut      = wb_en_q;
  assign MEM_R_ENOut   = mem_r_en_q;
  assign ALU_ResOut    = alu_res_q;
  assign DataMemoryOut = data_q;
  assign DestOut       = dest_q;
  assign addr_err      = addr_err_q;

endmodule

// File: doc/mem_wait_stage.md
# mem_wait_stage

Parametrised MEM stage for the ARM pipeline, placed between the EXE/MEM register and the WB stage. It owns the data memory, models a fixed multi-cycle memory latency, and drives `ready` low to freeze upstream stages while an access is outstanding. It also contains the MEM/WB pipeline register, which receives a bubble on every stalled cycle.

## Interface

Parameters:
- `N`, 32, data and address width.
- `ADDR_W`, 6, word-address bits; memory depth is 2^ADDR_W words.
- `WAIT_CYCLES`, 3, memory latency in cycles; legal range ≥1.
- `BASE_ADDR`, 1024, byte address of word 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ALU_ResIn`  in  N  byte address, or pass-through result.
- `Value_RmIn`  in  N  store data.
- `MEM_R_ENIn`, `MEM_W_ENIn`, `WB_ENIn`  in  1 each  control bits from EXE/MEM.
- `DestIn`  in  4  destination register.
- `ready`  out  1  0 means freeze the PC, IF/ID, ID/EXE and EXE/MEM registers.
- `WB_ENOut`, `MEM_R_ENOut`  out  1 each  registered control bits.
- `ALU_ResOut`  out  N  registered ALU result.
- `DataMemoryOut`  out  N  registered load data.
- `DestOut`  out  4  registered destination register.
- `addr_err`  out  1  registered; high when the access in the WB slot was out of range.

## Operation

- Request: `req = MEM_R_ENIn | MEM_W_ENIn`. When both enables are high, the access is treated as a write and `MEM_R_ENOut` is captured as 0.
- Word index: `(ALU_ResIn - BASE_ADDR) >> 2`. The low two address bits are ignored.
- Range check: the access is in range when `ALU_ResIn - BASE_ADDR` (N-bit unsigned) is less than `4 << ADDR_W`. Out-of-range handling:
  - reads return 0;
  - writes are dropped;
  - `addr_err` is captured as 1.
- FSM states and transitions:
  - IDLE, `!req`: stay in IDLE; `ready=1`; MEM/WB loads the inputs every cycle (non-memory instructions pass with no stall).
  - IDLE, `req`: go to BUSY; load `cnt = WAIT_CYCLES-1`; `ready=0`.
  - BUSY, `cnt!=0`: decrement `cnt`; `ready=0`.
  - BUSY, `cnt==0`: go to DONE; `ready=0`.
  - DONE: `ready=1`. At the closing edge the write commits, MEM/WB captures the read data and controls, and the FSM returns to IDLE.
- Stalled cycles (`ready=0`) load a bubble into MEM/WB: `WB_ENOut=0`, `MEM_R_ENOut=0`, `addr_err=0`. The other MEM/WB fields are don't-care.
- Back-to-back memory instructions: after DONE, IDLE sees the new request and starts a new access. There are no idle cycles beyond the IDLE request cycle.
- Inputs must hold stable while `ready=0`, because upstream is frozen. The block does not latch the inputs.

## Timing

- Reset values:
  - state IDLE, `cnt=0`;
  - all MEM/WB outputs 0, including `addr_err`;
  - `ready=1`.
- Memory contents are not cleared by `rst`.
- Memory access latency:
  - `ready` is low for WAIT_CYCLES+1 consecutive cycles, starting in the request cycle.
  - `ready` is high in the DONE cycle.
  - Results appear on MEM/WB outputs in the cycle after DONE.
  - With WAIT_CYCLES=3: request in cycle 0, `ready=0` in cycles 0–3, DONE in cycle 4, `DataMemoryOut` valid in cycle 5.
- Non-memory instruction: 1-cycle pass-through into MEM/WB.
- Reset mid-access: the FSM returns to IDLE on that edge and the pending write is discarded. If `rst` coincides with DONE, the write is also discarded.
- Memory array: asynchronous read, synchronous write. The write enable is asserted only in the DONE state, when in range and not in reset.

## Structure

- Shared package/include `mem_stage_defs`:
  - state encodings `S_IDLE`, `S_BUSY`, `S_DONE` (2 bits);
  - default `BASE_ADDR`.
- Sub-module `data_memory_array`:
  - parameters `N`, `ADDR_W`;
  - ports: `clk`, `we`, word address, write data, asynchronous read data.
- Top level contains the FSM, the counter, the range check and the MEM/WB register.

## Test plan

- Reset then idle: assert `rst` for 2 cycles, then drive a non-memory instruction (`WB_ENIn=1`, `DestIn=5`, `ALU_ResIn=0x2A`) -> `ready` stays 1; next cycle `WB_ENOut=1`, `DestOut=5`, `ALU_ResOut=0x2A`, `addr_err=0`.
- Store then load, WAIT_CYCLES=3: store 0xDEADBEEF to 1028, then load 1028 -> `ready` low 4 cycles for each access; each access's WB slot holds a bubble during its stall; load result `DataMemoryOut=0xDEADBEEF`, `MEM_R_ENOut=1`.
- Out of range: load from 1020, then store 0x1 to `1024+4·64`, then load word 0 -> `addr_err=1` with `DataMemoryOut=0` for the 1020 load; `addr_err=1` for the store; word 0 unchanged.
- Both enables high at 1032 with data 0x55 -> treated as a write; `MEM_R_ENOut=0`; a later load of 1032 returns 0x55.
- Reset mid-access: assert `rst` during the BUSY cycle of a store of 0x77 to 1036 -> `ready=1` the next cycle, outputs 0, and a later load of 1036 returns the prior value.
- Latency sweep: WAIT_CYCLES=1 and WAIT_CYCLES=5 -> `ready` low for exactly 2 and 6 cycles respectively.
